// File: rtl/aoi_gate_exerciser.sv
// -----------------------------------------------------------------------------
// aoi_gate_exerciser
//
// Stimulus/response engine for a four-input AOI gate. After a start pulse it
// walks all 16 input vectors {a,b,c,d}, holds each for SETTLE_CYCLES+1 clocks,
// samples the gate outputs on the last edge of that window and compares them
// against the golden function:
//   e = a & b,  f = c & d,  g = ~(e | f)
// Results (error count, first failing vector, sticky per-output fail flags,
// pass) hold until the next start.
//
// Parameters
//   SETTLE_CYCLES  cycles a vector is held before it is sampled (0..15)
//
// Ports
//   clk, resetn        clock (rising edge), async active-low reset
//   start              single-cycle sweep request (ignored while busy)
//   dut_a..dut_d       drives to the gate inputs (= vec[3:0])
//   dut_e..dut_g       gate outputs being checked
//   busy               sweep in progress
//   done               sweep complete (level, held until restart)
//   pass               done with zero failing vectors
//   err_count          number of failing vectors, 0..16
//   first_fail_vec     {a,b,c,d} of the first failing vector
//   first_fail_valid   first_fail_vec holds a captured vector
//   fail_bits          sticky mismatch flags: [2]=e, [1]=f, [0]=g
// -----------------------------------------------------------------------------
module aoi_gate_exerciser #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       dut_a,
    output logic       dut_b,
    output logic       dut_c,
    output logic       dut_d,
    input  logic       dut_e,
    input  logic       dut_f,
    input  logic       dut_g,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid,
    output logic [2:0] fail_bits
);

    // Only the low four bits of the parameter are meaningful (legal 0..15).
    localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] vec;
    logic [3:0] settle_cnt;

    // Golden response is derived from the registered vector, never from the
    // pins, so a broken wire between us and the gate shows up as a mismatch.
    logic       exp_e;
    logic       exp_f;
    logic       exp_g;
    logic [2:0] miss;
    logic       vec_fails;

    always_comb begin
        exp_e     = vec[3] & vec[2];
        exp_f     = vec[1] & vec[0];
        exp_g     = ~(exp_e | exp_f);
        miss      = {dut_e ^ exp_e, dut_f ^ exp_f, dut_g ^ exp_g};
        vec_fails = |miss;
    end

    // Pins come straight off the vector flops.
    assign dut_a = vec[3];
    assign dut_b = vec[2];
    assign dut_c = vec[1];
    assign dut_d = vec[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= IDLE;
            vec              <= 4'd0;
            settle_cnt       <= 4'd0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= 5'd0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
            fail_bits        <= 3'd0;
        end else begin
            case (state)
                // IDLE and DONE accept start identically; DONE just keeps the
                // previous results visible until then.
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SETTLE;
                        vec              <= 4'd0;
                        settle_cnt       <= SETTLE_LD;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= 5'd0;
                        first_fail_vec   <= 4'd0;
                        first_fail_valid <= 1'b0;
                        fail_bits        <= 3'd0;
                    end
                end

                // start is deliberately not looked at here.
                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        if (vec_fails) begin
                            err_count <= err_count + 5'd1;
                            fail_bits <= fail_bits | miss;
                            if (!first_fail_valid) begin
                                first_fail_vec   <= vec;
                                first_fail_valid <= 1'b1;
                            end
                        end

                        if (vec == 4'hF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // err_count has not absorbed this vector yet.
                            pass  <= (err_count == 5'd0) && !vec_fails;
                        end else begin
                            vec        <= vec + 4'd1;
                            settle_cnt <= SETTLE_LD;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aoi_gate_exerciser.sv
module tb_aoi_gate_exerciser;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    // Gate behaviour modes: 0 good, 1 g stuck 0, 2 f=c|d, 3 e=a^b,
    // 4 golden with a random per-vector corruption mask.
    int         mode;
    logic [2:0] rmask [16];

    function automatic logic [2:0] gate_fn(input int md, input logic [3:0] v, input logic [2:0] m);
        logic a, b, c, d, e, f, g;
        a = v[3]; b = v[2]; c = v[1]; d = v[0];
        e = a & b; f = c & d;
        case (md)
            2:       f = c | d;
            3:       e = a ^ b;
            default: ;
        endcase
        g = ~(e | f);
        if (md == 1) g = 1'b0;
        if (md == 4) return {e, f, g} ^ m;
        return {e, f, g};
    endfunction

    // Two instances: default settle time and zero settle time.
    logic       st2, st0;
    logic       a2, b2, c2, d2, e2, f2, g2, busy2, done2, pass2, ffv2;
    logic       a0, b0, c0, d0, e0, f0, g0, busy0, done0, pass0, ffv0;
    logic [4:0] err2, err0;
    logic [3:0] ffvec2, ffvec0;
    logic [2:0] fb2, fb0;

    assign {e2, f2, g2} = gate_fn(mode, {a2, b2, c2, d2}, rmask[{a2, b2, c2, d2}]);
    assign {e0, f0, g0} = gate_fn(mode, {a0, b0, c0, d0}, rmask[{a0, b0, c0, d0}]);

    aoi_gate_exerciser #(.SETTLE_CYCLES(2)) u_s2 (
        .clk(clk), .resetn(resetn), .start(st2),
        .dut_a(a2), .dut_b(b2), .dut_c(c2), .dut_d(d2),
        .dut_e(e2), .dut_f(f2), .dut_g(g2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2), .fail_bits(fb2));

    aoi_gate_exerciser #(.SETTLE_CYCLES(0)) u_s0 (
        .clk(clk), .resetn(resetn), .start(st0),
        .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0),
        .dut_e(e0), .dut_f(f0), .dut_g(g0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_fail_vec(ffvec0), .first_fail_valid(ffv0), .fail_bits(fb0));

    // Observation mux: sel=0 -> SETTLE_CYCLES=2 instance, sel=1 -> 0.
    bit sel;
    logic       o_busy, o_done, o_pass, o_ffv;
    logic [3:0] o_pins, o_ffvec;
    logic [4:0] o_err;
    logic [2:0] o_fb;
    assign o_busy  = sel ? busy0 : busy2;
    assign o_done  = sel ? done0 : done2;
    assign o_pass  = sel ? pass0 : pass2;
    assign o_ffv   = sel ? ffv0 : ffv2;
    assign o_pins  = sel ? {a0, b0, c0, d0} : {a2, b2, c2, d2};
    assign o_ffvec = sel ? ffvec0 : ffvec2;
    assign o_err   = sel ? err0 : err2;
    assign o_fb    = sel ? fb0 : fb2;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) st0 = v; else st2 = v;
    endtask

    // Reference: walk the truth table and tally where the gate disagrees
    // with the AOI function.
    task automatic model(output int exp_err, output logic [2:0] exp_fb,
                         output logic [3:0] exp_first, output logic exp_fv);
        exp_err = 0; exp_fb = 3'b000; exp_first = 4'd0; exp_fv = 1'b0;
        for (int v = 0; v < 16; v++) begin
            logic [2:0] gold, got;
            int a, b, c, d;
            a = (v >> 3) & 1; b = (v >> 2) & 1; c = (v >> 1) & 1; d = v & 1;
            gold = {a * b == 1, c * d == 1, (a * b + c * d) == 0};
            got  = gate_fn(mode, 4'(v), rmask[v]);
            if (got != gold) begin
                exp_err++;
                exp_fb |= got ^ gold;
                if (!exp_fv) begin exp_first = 4'(v); exp_fv = 1'b1; end
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".busy"}, 32'(o_busy), 0);
        chk({tag, ".done"}, 32'(o_done), 0);
        chk({tag, ".pass"}, 32'(o_pass), 0);
        chk({tag, ".err"},  32'(o_err), 0);
        chk({tag, ".ffv"},  32'(o_ffv), 0);
        chk({tag, ".ffvec"}, 32'(o_ffvec), 0);
        chk({tag, ".fb"},   32'(o_fb), 0);
        chk({tag, ".pins"}, 32'(o_pins), 0);
    endtask

    // Pulse start, then count edges from the start edge to done.
    task automatic sweep(input string tag, input bit extra_starts, input int exp_cycles);
        int cyc;
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        chk({tag, ".busy_at_start"}, 32'(o_busy), 1);
        chk({tag, ".done_cleared"}, 32'(o_done), 0);
        chk({tag, ".pass_cleared"}, 32'(o_pass), 0);
        chk({tag, ".pins_vec0"}, 32'(o_pins), 0);
        cyc = 0;
        while (cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            set_start(extra_starts && (cyc == 5 || cyc == 20));
            if (o_done) break;
        end
        set_start(1'b0);
        chk({tag, ".done_cycles"}, 32'(cyc), 32'(exp_cycles));
    endtask

    task automatic check_results(input string tag);
        int ee; logic [2:0] efb; logic [3:0] ef; logic efv;
        model(ee, efb, ef, efv);
        chk({tag, ".done"},  32'(o_done), 1);
        chk({tag, ".busy"},  32'(o_busy), 0);
        chk({tag, ".err"},   32'(o_err), 32'(ee));
        chk({tag, ".fb"},    32'(o_fb), 32'(efb));
        chk({tag, ".ffv"},   32'(o_ffv), 32'(efv));
        chk({tag, ".ffvec"}, 32'(o_ffvec), 32'(ef));
        chk({tag, ".pass"},  32'(o_pass), 32'(ee == 0));
        chk({tag, ".pins_vec15"}, 32'(o_pins), 15);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rmask[i] = 3'b000;
        mode = 0; sel = 0; st2 = 0; st0 = 0;
        resetn = 1'b0;
        #23;
        check_reset_vals("reset_s2");
        sel = 1; #1 check_reset_vals("reset_s0"); sel = 0;
        resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("idle_no_start");

        // Good gate.
        mode = 0;
        sweep("good", 0, 48);
        check_results("good");

        // g stuck at 0.
        mode = 1;
        sweep("g_stuck0", 0, 48);
        check_results("g_stuck0");
        chk("g_stuck0.err_const", 32'(o_err), 9);
        chk("g_stuck0.ffvec_const", 32'(o_ffvec), 0);
        chk("g_stuck0.fb_const", 32'(o_fb), 3'b001);

        // f = c|d.
        mode = 2;
        sweep("f_or", 0, 48);
        check_results("f_or");
        chk("f_or.err_const", 32'(o_err), 8);
        chk("f_or.ffvec_const", 32'(o_ffvec), 4'b0001);
        chk("f_or.fb_const", 32'(o_fb), 3'b011);

        // e = a^b: ab=01,10 and 11 all disagree with a&b, so 12 vectors fail
        // (1100 among them), first at 0100.
        mode = 3;
        sweep("e_xor", 0, 48);
        check_results("e_xor");
        chk("e_xor.err_const", 32'(o_err), 12);
        chk("e_xor.ffvec_const", 32'(o_ffvec), 4'b0100);
        chk("e_xor.fb_const", 32'(o_fb), 3'b101);

        // Start while busy is ignored; restart from DONE reruns cleanly.
        mode = 0;
        sweep("busy_start", 1, 48);
        check_results("busy_start");
        sweep("restart_done", 0, 48);
        check_results("restart_done");

        // Reset mid-sweep.
        @(posedge clk); #1 set_start(1'b1);
        @(posedge clk); #1 set_start(1'b0);
        repeat (30) @(posedge clk);
        #1 resetn = 1'b0;
        #1 check_reset_vals("midreset");
        @(posedge clk); #1 resetn = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            repeat (60) begin
                @(posedge clk); #1;
                if (o_done || o_busy) seen_done++;
            end
            chk("midreset.no_activity", 32'(seen_done), 0);
        end

        // Zero settle time.
        sel = 1;
        sweep("s0_good", 0, 16);
        check_results("s0_good");

        // Randomized corruption tables on both instances.
        mode = 4;
        for (int it = 0; it < 6; it++) begin
            for (int v = 0; v < 16; v++)
                rmask[v] = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            if (it == 3) for (int v = 0; v < 16; v++) rmask[v] = 3'b000;
            sel = it[0];
            sweep("rand", 0, sel ? 16 : 48);
            check_results("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
